// File: rtl/ipdc_op_ctrl.sv
// Op sequencer for the image-display datapath: frame-buffer load, window shift/scale, window readout.
// Optional feature: define IPDC_OP_CTRL_MODE_ERR_EN to make op 111 raise o_op_err and skip the display.
module ipdc_op_ctrl #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_op_valid,
    input  logic [2:0]                    i_op_mode,
    input  logic                          i_in_valid,
    output logic                          o_op_ready,
    output logic                          o_in_ready,
    output logic                          o_mem_we,
    output logic                          o_rd_en,
    output logic [2*$clog2(IMG_W)-1:0]    o_mem_addr,
    output logic                          o_out_valid,
    output logic                          o_out_last,
    output logic                          o_op_err
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned AW = 2 * CW;

    typedef enum logic [2:0] {StIdle, StLoad, StUpdate, StDisplay, StDrain} state_e;

    state_e            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [CW-1:0]     x_q, x_d, y_q, y_d;
    logic              size4_q, size4_d;
    logic [AW-1:0]     load_cnt_q, load_cnt_d;
    logic [CW-1:0]     r_q, r_d, c_q, c_d;
    logic [RD_LAT-1:0] vld_q, last_q;
    logic              started_q;
    logic              rd_last;

    logic [CW-1:0] size_m1;
    logic [CW:0]   x_ext, y_ext, size_w, img_w, four_w;

    assign size_m1 = size4_q ? CW'(3) : CW'(1);
    assign x_ext   = {1'b0, x_q};
    assign y_ext   = {1'b0, y_q};
    assign size_w  = size4_q ? (CW+1)'(4) : (CW+1)'(2);
    assign img_w   = (CW+1)'(IMG_W);
    assign four_w  = (CW+1)'(4);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        x_d        = x_q;
        y_d        = y_q;
        size4_d    = size4_q;
        load_cnt_d = load_cnt_q;
        r_d        = r_q;
        c_d        = c_q;
        rd_last    = 1'b0;
        o_op_ready = 1'b0;
        o_in_ready = 1'b0;
        o_mem_we   = 1'b0;
        o_rd_en    = 1'b0;
        o_mem_addr = '0;
`ifdef IPDC_OP_CTRL_MODE_ERR_EN
        o_op_err   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                // Ready only from the first edge after reset release.
                o_op_ready = started_q;
                if (started_q && i_op_valid) begin
                    mode_d  = i_op_mode;
                    state_d = (i_op_mode == 3'b000) ? StLoad : StUpdate;
                end
            end
            StLoad: begin
                o_in_ready = 1'b1;
                o_mem_addr = load_cnt_q;
                if (i_in_valid) begin
                    o_mem_we   = 1'b1;
                    load_cnt_d = load_cnt_q + AW'(1);
                    if (&load_cnt_q) begin
                        x_d     = '0;
                        y_d     = '0;
                        size4_d = 1'b1;
                        state_d = StDisplay;
                    end
                end
            end
            StUpdate: begin
                state_d = StDisplay;
                case (mode_q)
                    3'b001: if (x_ext + size_w < img_w) x_d = x_q + CW'(1);
                    3'b010: if (x_q != '0) x_d = x_q - CW'(1);
                    3'b011: if (y_q != '0) y_d = y_q - CW'(1);
                    3'b100: if (y_ext + size_w < img_w) y_d = y_q + CW'(1);
                    3'b101: size4_d = 1'b0;
                    3'b110: if (x_ext + four_w <= img_w && y_ext + four_w <= img_w) size4_d = 1'b1;
`ifdef IPDC_OP_CTRL_MODE_ERR_EN
                    3'b111: begin
                        o_op_err = 1'b1;
                        state_d  = StIdle;
                    end
`endif
                    default: ;
                endcase
            end
            StDisplay: begin
                o_rd_en    = 1'b1;
                // IMG_W is a power of two, so y*IMG_W+x is a concatenation.
                o_mem_addr = {y_q + r_q, x_q + c_q};
                c_d        = c_q + CW'(1);
                if (c_q == size_m1) begin
                    c_d = '0;
                    r_d = r_q + CW'(1);
                    if (r_q == size_m1) begin
                        r_d     = '0;
                        rd_last = 1'b1;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (last_q[RD_LAT-1]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifndef IPDC_OP_CTRL_MODE_ERR_EN
    assign o_op_err = 1'b0;
`endif

    assign o_out_valid = vld_q[RD_LAT-1];
    assign o_out_last  = last_q[RD_LAT-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            mode_q     <= 3'b000;
            x_q        <= '0;
            y_q        <= '0;
            size4_q    <= 1'b1;
            load_cnt_q <= '0;
            r_q        <= '0;
            c_q        <= '0;
            vld_q      <= '0;
            last_q     <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            x_q        <= x_d;
            y_q        <= y_d;
            size4_q    <= size4_d;
            load_cnt_q <= load_cnt_d;
            r_q        <= r_d;
            c_q        <= c_d;
            started_q  <= 1'b1;
            vld_q[0]   <= o_rd_en;
            last_q[0]  <= rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end
endmodule

// File: doc/ipdc_op_ctrl.md
Name: ipdc_op_ctrl

Overview:
- Operation sequencer for the image-display datapath.
- Accepts one op command at a time and runs the 64-pixel load handshake into the 8x8 RGB frame buffer.
- Keeps the display window state: origin (x,y) and size 4x4 or 2x2.
- After every op, issues the row-major read addresses for the window and generates a latency-aligned output-valid strobe for the pixel datapath.

Parameters:
- IMG_W, 8, image width/height in pixels; power of two; address width = 2*log2(IMG_W).
- RD_LAT, 1, cycles from o_rd_en/o_mem_addr to pixel data at datapath output; range 1..4.

Ports:
- i_clk  in  1  clock, all state changes on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_op_valid  in  1  command strobe; sampled only while o_op_ready=1.
- i_op_mode  in  3  op code, see Behaviour.
- i_in_valid  in  1  pixel strobe during load.
- o_op_ready  out  1  controller idle, command accepted this cycle if i_op_valid=1.
- o_in_ready  out  1  load phase active.
- o_mem_we  out  1  frame-buffer write enable (= i_in_valid & o_in_ready).
- o_rd_en  out  1  frame-buffer read enable.
- o_mem_addr  out  6  write/read address, y*IMG_W+x.
- o_out_valid  out  1  datapath output pixel valid (o_rd_en delayed RD_LAT).
- o_out_last  out  1  with o_out_valid on final window pixel.
- o_op_err  out  1  one-cycle illegal-op pulse (optional feature only).

Behaviour:
- Reset values:
  - state=IDLE, origin=(0,0), size=4, load/display counters 0.
  - All outputs 0, including o_op_ready.
  - o_op_ready rises on the first rising edge after reset release.
- Op codes:
  - 000 load.
  - 001 shift right (x+1).
  - 010 shift left (x-1).
  - 011 shift up (y-1).
  - 100 shift down (y+1).
  - 101 scale down (size 2).
  - 110 scale up (size 4).
  - 111 reserved.
- FSM:
  - IDLE: o_op_ready=1. i_op_valid=1 captures the mode; o_op_ready drops next cycle. Mode 000 goes to LOAD. Modes 001-110 go to UPDATE. Mode 111 goes to UPDATE with no change.
  - LOAD: o_in_ready=1. Each i_in_valid cycle writes address = load count, then increments it. i_in_valid=0 stalls with no write. After the 64th write (address 63): origin=(0,0), size=4, go to DISPLAY. o_in_ready is 0 in the cycle after the last write.
  - UPDATE: one cycle, applies the origin/size change, then goes to DISPLAY.
  - DISPLAY: one read per cycle, o_rd_en=1, addr=(y+r)*IMG_W+(x+c). Row-major r,c = 0..size-1, size*size cycles total, then DRAIN.
  - DRAIN: waits until the o_out_last pulse has been emitted (RD_LAT cycles after the last read), then returns to IDLE.
- Boundary rules (violating ops leave state unchanged but still display the window):
  - Shift right only if x+size < IMG_W; shift left only if x > 0.
  - Shift up only if y > 0; shift down only if y+size < IMG_W.
  - Scale down always sets size=2, origin kept.
  - Scale up only if x+4 ≤ IMG_W and y+4 ≤ IMG_W; size already 4 means no change.
- Latency:
  - Command accept to first o_rd_en is 2 cycles for non-load ops.
  - First o_out_valid follows RD_LAT cycles after that.
- Handshake rules:
  - i_op_valid outside IDLE is ignored.
  - i_in_valid outside LOAD is ignored; no write occurs.
  - o_in_ready and o_rd_en are never high together.
- Reset mid-operation aborts immediately to reset values.
  - Partial loads are not resumed.
  - The in-flight valid pipeline is cleared.

Optional Feature:
- Macro IPDC_OP_CTRL_MODE_ERR_EN.
- Defined: mode 111 pulses o_op_err for 1 cycle, skips UPDATE/DISPLAY, and returns to IDLE (o_op_ready=1 two cycles after accept).
- Undefined: o_op_err is tied to 0, and mode 111 is a no-change op that still displays the window.

Test Plan:
- Reset, load 64 pixels with i_in_valid toggling every other cycle → exactly 64 writes at addr 0..63 in order; then 16 reads at addr 0,1,2,3,8,...,27; o_out_last on the 16th valid.
- After load, shift right ×5 → x goes 1,2,3,4,4 (5th clamped); the final display first addr is 4, last addr is 31.
- Scale down at origin (4,0), then shift down ×7 → y stops at 6; window addrs 52,53,60,61; 4 valids per op.
- From origin (6,6) size 2, scale up → no change, 4 reads 54,55,62,63. Then shift left ×2 and shift up ×2, then scale up → size 4 at (4,4), first addr 36.
- RD_LAT=3: any shift op → o_out_valid lags o_rd_en by exactly 3 cycles; o_op_ready returns only after o_out_last.
- Assert i_rst_n low during LOAD at pixel 20, then reload → writes restart at addr 0. With IPDC_OP_CTRL_MODE_ERR_EN, mode 111 → o_op_err pulses 1 cycle and o_rd_en is never asserted.
